product_denormalizer: RTL



---
 rtl/product_denormalizer_if.sv | 24 ++
 rtl/product_denormalizer.sv | 76 +++++++
 2 files changed

// File: rtl/product_denormalizer_if.sv
// Handshake and data bundle between a sequencing controller and product_denormalizer.
// The controller side uses the master modport and the denormalizer uses the slave modport.
interface product_denormalizer_if #(
  parameter int PW = 16,
  parameter int CW = 5
);
  logic            start;
  logic [PW-1:0]   product_in;
  logic [CW-1:0]   shift_count;
  logic            ready;
  logic            busy;
  logic            done;
  logic [2*PW-1:0] result_out;

  modport master (
    output start, product_in, shift_count,
    input  ready, busy, done, result_out
  );

  modport slave (
    input  start, product_in, shift_count,
    output ready, busy, done, result_out
  );
endinterface

// File: rtl/product_denormalizer.sv
// Undoes operand normalization by right-shifting {product, zeros} one bit per clock.
// The result is held in result_out until the next completion, which is flagged by a one-cycle done.
module product_denormalizer #(
  parameter int PW = 16,
  parameter int CW = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  product_denormalizer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2*PW-1:0] frame_q, frame_d;
  logic [2*PW-1:0] result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // NOTE: every signal driven here gets a hold-value default first, so no latches are inferred.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          frame_d = {bus.product_in, {PW{1'b0}}};
          cnt_d   = bus.shift_count;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The count is checked before decrementing, so the maximum count never wraps.
        if (cnt_q != '0) begin
          frame_d = frame_q >> 1;
          cnt_d   = cnt_q - CW'(1);
        end else begin
          result_d = frame_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready      = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.result_out = result_q;

endmodule
